// File: rtl/rmii_fifo_ctrl_if.sv
// rmii_fifo_ctrl_if: handshake and buffer-control bundle for rmii_fifo_ctrl.
// master = receive front-end / consumer side, slave = the controller.
interface rmii_fifo_ctrl_if #(
    parameter int AW = 9
);
    logic          i_rx_valid;
    logic          i_rx_eof;
    logic          i_rd_en;
    logic          o_enab_write;
    logic [AW-1:0] o_addr_write;
    logic [AW-1:0] o_addr_read;
    logic          o_rd_valid;
    logic [AW:0]   o_avail;
    logic          o_full;
    logic          o_drop;

    modport master (
        output i_rx_valid, i_rx_eof, i_rd_en,
        input  o_enab_write, o_addr_write, o_addr_read,
        input  o_rd_valid, o_avail, o_full, o_drop
    );

    modport slave (
        input  i_rx_valid, i_rx_eof, i_rd_en,
        output o_enab_write, o_addr_write, o_addr_read,
        output o_rd_valid, o_avail, o_full, o_drop
    );
endinterface

// File: rtl/rmii_fifo_ctrl.sv
// rmii_fifo_ctrl: store-and-forward frame FIFO controller for RMII dibits.
// Drives the write/read addresses of an external dual-address dibit buffer.
// Frames become visible to the reader only once their end-of-frame arrives;
// a frame that overflows the buffer is rewound and reported with o_drop.
// Optional feature: define RMII_FIFO_CTRL_DROPCNT_EN to add the saturating
// 8-bit dropped-frame counter output o_drop_cnt.
module rmii_fifo_ctrl #(
    parameter int DEPTH = 288,
    parameter int AW    = 9
) (
    input  logic                i_clock,
    input  logic                i_reset,
    rmii_fifo_ctrl_if.slave     bus
`ifdef RMII_FIFO_CTRL_DROPCNT_EN
    ,
    output logic [7:0]          o_drop_cnt
`endif
);

    typedef enum logic [1:0] {
        W_IDLE,
        W_RECV,
        W_DROP
    } wstate_t;

    localparam logic [AW:0]   DEPTH_C = (AW+1)'(DEPTH);
    localparam logic [AW-1:0] LAST_C  = AW'(DEPTH - 1);

    wstate_t       state_reg;
    logic [AW-1:0] wr_ptr_reg;
    logic [AW-1:0] cm_ptr_reg;
    logic [AW-1:0] rd_ptr_reg;
    logic [AW:0]   used_reg;
    logic [AW:0]   avail_reg;
    logic          drop_reg;

    logic          full_w;
    logic          pop_w;
    logic          accepting_w;
    logic          we_w;
    logic          overflow_w;
    logic          drop_set_w;
    logic [AW:0]   pop_amt_w;
    logic [AW:0]   we_amt_w;
    logic [AW:0]   inflight_w;

    function automatic logic [AW-1:0] ptr_inc(input logic [AW-1:0] p);
        return (p == LAST_C) ? '0 : AW'(p + 1'b1);
    endfunction

    // Space is judged only from registered occupancy, so a pop in the same
    // cycle never makes room for a write in that cycle.
    assign full_w      = (used_reg == DEPTH_C);
    assign pop_w       = bus.i_rd_en && (avail_reg != '0);
    assign accepting_w = (state_reg != W_DROP);
    assign we_w        = accepting_w && bus.i_rx_valid && !full_w;
    assign overflow_w  = accepting_w && bus.i_rx_valid && full_w;
    assign drop_set_w  = bus.i_rx_eof && (overflow_w || (state_reg == W_DROP));
    assign pop_amt_w   = {{AW{1'b0}}, pop_w};
    assign we_amt_w    = {{AW{1'b0}}, we_w};
    // Dibits written for the current frame but not yet committed.
    assign inflight_w  = used_reg - avail_reg;

    // Write FSM, commit/rewind of the frame, and read pointer bookkeeping.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            state_reg  <= W_IDLE;
            wr_ptr_reg <= '0;
            cm_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            used_reg   <= '0;
            avail_reg  <= '0;
            drop_reg   <= 1'b0;
        end else begin
            drop_reg  <= drop_set_w;
            avail_reg <= avail_reg - pop_amt_w;
            used_reg  <= used_reg + we_amt_w - pop_amt_w;
            if (pop_w) begin
                rd_ptr_reg <= ptr_inc(rd_ptr_reg);
            end
            case (state_reg)
                W_IDLE, W_RECV: begin
                    if (overflow_w) begin
                        // Discard the partial frame: rewind to the last commit.
                        wr_ptr_reg <= cm_ptr_reg;
                        used_reg   <= avail_reg - pop_amt_w;
                        state_reg  <= bus.i_rx_eof ? W_IDLE : W_DROP;
                    end else if (bus.i_rx_valid || (state_reg == W_RECV)) begin
                        if (we_w) begin
                            wr_ptr_reg <= ptr_inc(wr_ptr_reg);
                        end
                        if (bus.i_rx_eof) begin
                            cm_ptr_reg <= we_w ? ptr_inc(wr_ptr_reg) : wr_ptr_reg;
                            avail_reg  <= avail_reg + inflight_w + we_amt_w - pop_amt_w;
                            state_reg  <= W_IDLE;
                        end else begin
                            state_reg  <= W_RECV;
                        end
                    end
                end
                W_DROP: begin
                    if (bus.i_rx_eof) begin
                        state_reg <= W_IDLE;
                    end
                end
                default: state_reg <= W_IDLE;
            endcase
        end
    end

`ifdef RMII_FIFO_CTRL_DROPCNT_EN
    logic [7:0] drop_cnt_reg;

    // Saturating count of dropped frames, updated with each drop pulse.
    always_ff @(posedge i_clock) begin
        if (i_reset) begin
            drop_cnt_reg <= '0;
        end else if (drop_set_w && (drop_cnt_reg != 8'hFF)) begin
            drop_cnt_reg <= drop_cnt_reg + 8'd1;
        end
    end

    assign o_drop_cnt = drop_cnt_reg;
`endif

    assign bus.o_enab_write = we_w;
    assign bus.o_addr_write = wr_ptr_reg;
    assign bus.o_addr_read  = rd_ptr_reg;
    assign bus.o_rd_valid   = (avail_reg != '0);
    assign bus.o_avail      = avail_reg;
    assign bus.o_full       = full_w;
    assign bus.o_drop       = drop_reg;

endmodule

// File: tb/tb_rmii_fifo_ctrl.sv
// tb_rmii_fifo_ctrl: directed scoreboard bench for rmii_fifo_ctrl.
// Committed frames push (address, dibit) pairs into a queue; a monitor pops
// and compares them whenever the consumer reads valid data.
module tb_rmii_fifo_ctrl;

    localparam int DEPTH = 288;
    localparam int AW    = 9;

    typedef struct {
        int addr;
        int data;
    } exp_t;

    logic       clk;
    logic       rst;
    logic [1:0] rx_data;
    logic [1:0] mem [0:(1<<AW)-1];
    exp_t       sb_q[$];
    int         errors;
    int         checks;
    int         exp_wr;

    rmii_fifo_ctrl_if #(.AW(AW)) bus ();

`ifdef RMII_FIFO_CTRL_DROPCNT_EN
    logic [7:0] drop_cnt;
`endif

    rmii_fifo_ctrl #(
        .DEPTH (DEPTH),
        .AW    (AW)
    ) dut (
        .i_clock    (clk),
        .i_reset    (rst),
        .bus        (bus)
`ifdef RMII_FIFO_CTRL_DROPCNT_EN
        ,
        .o_drop_cnt (drop_cnt)
`endif
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Model of the attached dibit buffer: synchronous write, combinational read.
    always @(posedge clk) begin
        if (bus.o_enab_write) mem[bus.o_addr_write] <= rx_data;
    end

    task automatic check(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            errors++;
            $display("FAIL %s: got %0d expected %0d", name, act, exp);
        end
    endtask

    // Monitor: every accepted pop must match the oldest expected dibit.
    always @(negedge clk) begin
        exp_t e;
        if (!rst && bus.i_rd_en && bus.o_rd_valid) begin
            if (sb_q.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL pop_unexpected: got addr %0d expected no data", bus.o_addr_read);
            end else begin
                e = sb_q.pop_front();
                check("pop_addr", int'(bus.o_addr_read), e.addr);
                check("pop_data", int'(mem[bus.o_addr_read]), e.data);
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        bus.i_rx_valid = 1'b0;
        bus.i_rx_eof   = 1'b0;
        bus.i_rd_en    = 1'b0;
    endtask

    task automatic do_reset();
        idle_inputs();
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        sb_q.delete();
        exp_wr = 0;
    endtask

    // Send a frame of len dibits; the first accept_n are expected to be stored.
    // A frame is committed only when all dibits are accepted.
    task automatic send_frame(input int len, input bit eof_with_last,
                              input int accept_n, input int seed,
                              input int avail_during);
        exp_t fr[$];
        bit   commit;
        commit = (accept_n == len);
        for (int i = 0; i < len; i++) begin
            rx_data        = 2'(i + seed);
            bus.i_rx_valid = 1'b1;
            bus.i_rx_eof   = eof_with_last && (i == len - 1);
            if (i < accept_n) fr.push_back('{(exp_wr + i) % DEPTH, int'(rx_data)});
            #1;
            check("enab_write", int'(bus.o_enab_write), (i < accept_n) ? 1 : 0);
            if (i <= accept_n) check("addr_write", int'(bus.o_addr_write), (exp_wr + i) % DEPTH);
            if (commit && bus.i_rx_eof) begin
                foreach (fr[k]) sb_q.push_back(fr[k]);
            end
            step();
            if (avail_during >= 0 && !bus.i_rx_eof) check("avail_in_frame", int'(bus.o_avail), avail_during);
            if (accept_n < len && i == accept_n - 1) check("full_at_limit", int'(bus.o_full), 1);
            if (accept_n < len && i == accept_n) check("wr_rewind", int'(bus.o_addr_write), exp_wr);
        end
        bus.i_rx_valid = 1'b0;
        if (!eof_with_last) begin
            bus.i_rx_eof = 1'b1;
            if (commit) foreach (fr[k]) sb_q.push_back(fr[k]);
            step();
        end
        bus.i_rx_eof = 1'b0;
        check("drop_pulse", int'(bus.o_drop), commit ? 0 : 1);
        if (commit) exp_wr = (exp_wr + len) % DEPTH;
        $display("frame len=%0d accepted=%0d committed=%0d", len, accept_n, commit);
    endtask

    task automatic pop_cycles(input int n);
        bus.i_rd_en = 1'b1;
        repeat (n) step();
        bus.i_rd_en = 1'b0;
        check("sb_drained", sb_q.size(), 0);
        $display("pop burst cycles=%0d rd_ptr=%0d", n, bus.o_addr_read);
    endtask

    initial begin
        errors = 0;
        checks = 0;
        rx_data = 2'd0;
        rst = 1'b1;
        idle_inputs();
        do_reset();

        // Reset state
        check("rst_avail", int'(bus.o_avail), 0);
        check("rst_rd_valid", int'(bus.o_rd_valid), 0);
        check("rst_full", int'(bus.o_full), 0);
        check("rst_drop", int'(bus.o_drop), 0);
        check("rst_addr_write", int'(bus.o_addr_write), 0);
        check("rst_addr_read", int'(bus.o_addr_read), 0);
        check("rst_enab_write", int'(bus.o_enab_write), 0);

        // 10-dibit frame, visible only after eof
        send_frame(10, 1'b0, 10, 1, 0);
        check("avail_after_eof", int'(bus.o_avail), 10);
        check("rd_valid_after_eof", int'(bus.o_rd_valid), 1);
        check("addr_write_10", int'(bus.o_addr_write), 10);

        // Zero-length frame in idle changes nothing
        bus.i_rx_eof = 1'b1;
        step();
        bus.i_rx_eof = 1'b0;
        step();
        check("zero_len_avail", int'(bus.o_avail), 10);
        check("zero_len_addr_write", int'(bus.o_addr_write), 10);
        check("zero_len_drop", int'(bus.o_drop), 0);

        // Pop all 10 plus extra ignored pops
        pop_cycles(12);
        check("pop_addr_read_end", int'(bus.o_addr_read), 10);
        check("pop_avail_end", int'(bus.o_avail), 0);
        check("pop_rd_valid_end", int'(bus.o_rd_valid), 0);

        // Oversized frame into an empty buffer is dropped
        do_reset();
        send_frame(300, 1'b0, 288, 2, 0);
        check("drop_one_cycle_avail", int'(bus.o_avail), 0);
        step();
        check("drop_pulse_end", int'(bus.o_drop), 0);
        check("drop_full_clear", int'(bus.o_full), 0);
        check("drop_addr_write", int'(bus.o_addr_write), 0);
`ifdef RMII_FIFO_CTRL_DROPCNT_EN
        check("drop_cnt_1", int'(drop_cnt), 1);
`endif

        // Pointer wrap: advance to 280, then a 20-dibit frame
        do_reset();
        send_frame(280, 1'b0, 280, 3, 0);
        pop_cycles(280);
        check("addr_read_280", int'(bus.o_addr_read), 280);
        send_frame(20, 1'b0, 20, 0, 0);
        check("wrap_addr_write", int'(bus.o_addr_write), 12);
        pop_cycles(20);
        check("wrap_addr_read", int'(bus.o_addr_read), 12);

        // Occupancy boundary at 287 with a simultaneous pop
        send_frame(287, 1'b0, 287, 1, 0);
        check("avail_287", int'(bus.o_avail), 287);
        rx_data        = 2'd1;
        bus.i_rx_valid = 1'b1;
        bus.i_rd_en    = 1'b1;
        #1;
        check("write_with_pop_at_287", int'(bus.o_enab_write), 1);
        check("not_full_287", int'(bus.o_full), 0);
        step();
        bus.i_rd_en = 1'b0;
        rx_data     = 2'd2;
        check("avail_after_pop", int'(bus.o_avail), 286);
        check("still_not_full", int'(bus.o_full), 0);
        #1;
        check("write_at_287", int'(bus.o_enab_write), 1);
        step();
        check("full_at_288", int'(bus.o_full), 1);
        bus.i_rx_valid = 1'b0;
        bus.i_rx_eof   = 1'b1;
        sb_q.push_back('{11, 1});
        sb_q.push_back('{12, 2});
        exp_wr = 13;
        step();
        bus.i_rx_eof = 1'b0;
        check("avail_288", int'(bus.o_avail), 288);
        check("full_kept", int'(bus.o_full), 1);
        // A frame arriving while full is dropped from its first dibit
        send_frame(3, 1'b0, 0, 0, -1);
        check("avail_kept_288", int'(bus.o_avail), 288);
`ifdef RMII_FIFO_CTRL_DROPCNT_EN
        check("drop_cnt_after_full", int'(drop_cnt), 1);
`endif
        pop_cycles(290);
        check("drained_avail", int'(bus.o_avail), 0);

        // Reset in the middle of a frame
        for (int i = 0; i < 5; i++) begin
            rx_data        = 2'(i);
            bus.i_rx_valid = 1'b1;
            step();
        end
        rst = 1'b1;
        step();
        rst = 1'b0;
        bus.i_rx_valid = 1'b0;
        sb_q.delete();
        exp_wr = 0;
        #1;
        check("mid_rst_avail", int'(bus.o_avail), 0);
        check("mid_rst_rd_valid", int'(bus.o_rd_valid), 0);
        check("mid_rst_full", int'(bus.o_full), 0);
        check("mid_rst_drop", int'(bus.o_drop), 0);
        check("mid_rst_addr_write", int'(bus.o_addr_write), 0);
        check("mid_rst_addr_read", int'(bus.o_addr_read), 0);
        check("mid_rst_enab_write", int'(bus.o_enab_write), 0);
`ifdef RMII_FIFO_CTRL_DROPCNT_EN
        check("mid_rst_drop_cnt", int'(drop_cnt), 0);
`endif
        step();
        send_frame(3, 1'b1, 3, 2, 0);
        check("post_rst_avail", int'(bus.o_avail), 3);
        pop_cycles(4);
        check("post_rst_addr_read", int'(bus.o_addr_read), 3);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    // Bound on total run time.
    initial begin
        #500000;
        errors++;
        checks++;
        $display("FAIL timeout: got no finish expected finish within bound");
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/rmii_fifo_ctrl.md
RMII_FIFO_CTRL -- requirements
Module: rmii_fifo_ctrl

Interface
REQ-001 Parameter DEPTH, default 288, SHALL set the number of 2-bit dibit locations in the attached dual-address buffer.
REQ-002 Parameter AW, default 9, SHALL set the address width; DEPTH <= 2^AW.
REQ-003 One clock; reset is synchronous and active-high. Ports SHALL be named i_clock and i_reset.
REQ-004 i_clock  in  1  sole clock; all state updates on its rising edge.
REQ-005 i_reset  in  1  synchronous active-high reset.
REQ-006 i_rx_valid  in  1  receive dibit present this cycle; the dibit drives the buffer data input directly.
REQ-007 i_rx_eof  in  1  one-cycle end-of-frame strobe.
REQ-008 i_rd_en  in  1  consumer pops the dibit at o_addr_read.
REQ-009 o_enab_write  out  1  buffer write enable.
REQ-010 o_addr_write  out  AW  buffer write address (wr_ptr).
REQ-011 o_addr_read  out  AW  buffer read address (rd_ptr); the buffer read is combinational.
REQ-012 o_rd_valid  out  1  committed unread data available; equals (o_avail != 0).
REQ-013 o_avail  out  AW+1  committed unread dibits, range 0..DEPTH.
REQ-014 o_full  out  1  used == DEPTH, where used = in-flight + committed unread dibits.
REQ-015 o_drop  out  1  one-cycle pulse when a dropped frame terminates.

Function
REQ-016 Pointers wr_ptr, cm_ptr (commit) and rd_ptr SHALL each advance by 1 and wrap DEPTH-1 -> 0.
REQ-017 used SHALL be held in a counter of width AW+1; it never exceeds DEPTH and never underflows.
REQ-018 Space SHALL be evaluated from register values at the start of the cycle; a same-cycle pop SHALL NOT create space for a same-cycle write.
REQ-019 Write FSM states SHALL be W_IDLE, W_RECV and W_DROP.
REQ-020 W_IDLE, i_rx_valid with space: o_enab_write=1, wr_ptr+1, go to W_RECV.
REQ-021 W_IDLE, i_rx_valid with o_full: no write, go to W_DROP.
REQ-022 W_RECV, i_rx_valid with space: write, wr_ptr+1.
REQ-023 W_RECV, i_rx_valid with o_full: no write; wr_ptr <= cm_ptr; used <= o_avail; go to W_DROP.
REQ-024 W_RECV, i_rx_eof: cm_ptr <= wr_ptr; go to W_IDLE.
REQ-025 W_RECV, i_rx_eof and i_rx_valid together: write the dibit if space exists and commit it (cm_ptr <= wr_ptr+1); if no space, take the drop action of REQ-023 and REQ-027 in the same cycle.
REQ-026 W_DROP: ignore i_rx_valid; o_enab_write=0.
REQ-027 W_DROP, i_rx_eof: o_drop=1 for one cycle, go to W_IDLE.
REQ-028 i_rx_eof in W_IDLE with no valid dibit is a zero-length frame: no state change, no commit.
REQ-029 o_enab_write SHALL be combinational from state, i_rx_valid and o_full, asserted only for accepted writes.
REQ-030 i_rd_en with o_avail != 0: rd_ptr+1 and o_avail-1 and used-1 next cycle.
REQ-031 i_rd_en with o_avail == 0: ignored; no pointer or counter change.
REQ-032 Simultaneous commit and pop: o_avail <= o_avail + frame_len - 1.
REQ-033 The read side SHALL never expose uncommitted or dropped dibits; store-and-forward only.

Reset
REQ-034 i_reset SHALL set state=W_IDLE; wr_ptr, cm_ptr and rd_ptr to 0; used and o_avail to 0; o_enab_write=0, o_rd_valid=0, o_full=0, o_drop=0.
REQ-035 Reset mid-frame SHALL discard all buffered and in-flight data; reset takes priority over all inputs.

Configuration
REQ-036 Macro RMII_FIFO_CTRL_DROPCNT_EN, when defined, SHALL add output o_drop_cnt (8 bits), reset to 0, incremented on every o_drop pulse and saturating at 255.
REQ-037 Without RMII_FIFO_CTRL_DROPCNT_EN the port and counter SHALL be absent; all other behaviour is identical.

Verification
REQ-038 Reset; 10 valid dibits then eof -> o_avail=10 one cycle after eof and o_rd_valid=1; o_avail=0 during the frame.
REQ-039 Pop 10 with i_rd_en held -> o_addr_read steps 0..9 then holds at 10; o_avail=0; further pops ignored.
REQ-040 Frame of 300 dibits into an empty buffer -> o_full after 288 writes; wr_ptr rewinds to 0; o_avail=0; o_drop pulses at eof (o_drop_cnt=1 when the macro is defined).
REQ-041 Pointers at 280; 20-dibit frame then pop all -> o_addr_write wraps 287 -> 0 and ends at 12; o_addr_read ends at 12.
REQ-042 Buffer at used=287; pop and valid in the same cycle -> write accepted (used=287 < 288), used stays 287; the next cycle with valid and no pop reaches 288 = o_full.
REQ-043 i_reset asserted mid-frame after 5 dibits -> all outputs at reset values the next cycle; a following 3-dibit frame commits o_avail=3.
